// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and
// the parity helper reused by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int MAX_DATA_BITS = 9;

  // Returns the parity bit a well-formed frame carries for this payload.
  function automatic logic parity_calc(
    input logic [MAX_DATA_BITS-1:0] data,
    input int                       mode
  );
    logic p;
    unique case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-to-consumer handshake: held frame, status flags and ack.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxAck;
  logic                 RxValid;
  logic [DATA_BITS-1:0] RxData;
  logic                 ParityError;
  logic                 FrameError;
  logic                 Overrun;

  modport master (
    input  RxAck,
    output RxValid,
    output RxData,
    output ParityError,
    output FrameError,
    output Overrun
  );

  modport slave (
    output RxAck,
    input  RxValid,
    input  RxData,
    input  ParityError,
    input  FrameError,
    input  Overrun
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic D,
  output logic Q
);
  logic meta;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta <= RESET_VAL;
      Q    <= RESET_VAL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with valid/ack holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority bit sampling.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Rx,
  input  logic Tick,
  output logic Busy,
  uart_rx_frame_if.master rxIf
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_rx_state_t state, stateNext;
  logic [TW-1:0] tickCnt, tickCntNext;
  logic [BW-1:0] bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic parErr, parErrNext;
  logic frmErr, frmErrNext;
  logic armed, armedNext;
  logic done;
  logic rxS;
  logic sampleBit;
  logic midBit;

  logic                 rxValid;
  logic [DATA_BITS-1:0] rxData;
  logic                 parityError;
  logic                 frameError;
  logic                 overrun;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) uSync (
    .Clock(Clock),
    .Reset(Reset),
    .D    (Rx),
    .Q    (rxS)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hist <= 2'b11;
    end else if (Tick) begin
      hist <= {hist[0], rxS};
    end
  end

  // Vote over the two previous ticks and the deciding tick.
  assign sampleBit = (hist[1] & hist[0]) |
                     (hist[1] & rxS) |
                     (hist[0] & rxS);
`else
  assign sampleBit = rxS;
`endif

  assign midBit = (tickCnt == BIT_LAST);
  assign Busy   = (state != IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      parErr   <= 1'b0;
      frmErr   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickCntNext;
      bitCnt   <= bitCntNext;
      shiftReg <= shiftNext;
      parErr   <= parErrNext;
      frmErr   <= frmErrNext;
      armed    <= armedNext;
    end
  end

  always_comb begin
    stateNext   = state;
    tickCntNext = tickCnt;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    parErrNext  = parErr;
    frmErrNext  = frmErr;
    armedNext   = armed;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        // A line stuck low after a break must go high before re-arming.
        if (rxS) begin
          armedNext = 1'b1;
        end else if (armed) begin
          stateNext   = START;
          tickCntNext = '0;
          parErrNext  = 1'b0;
          frmErrNext  = 1'b0;
        end
      end
      START: begin
        if (Tick) begin
          if (tickCnt == HALF_LAST) begin
            tickCntNext = '0;
            if (!sampleBit) begin
              stateNext  = DATA;
              bitCntNext = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            tickCntNext = tickCnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (Tick) begin
          if (midBit) begin
            tickCntNext = '0;
            shiftNext   = {sampleBit, shiftReg[DATA_BITS-1:1]};
            if (bitCnt == DATA_LAST) begin
              bitCntNext = '0;
              stateNext  = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              bitCntNext = bitCnt + BW'(1);
            end
          end else begin
            tickCntNext = tickCnt + TW'(1);
          end
        end
      end
      PARITY: begin
        if (Tick) begin
          if (midBit) begin
            tickCntNext = '0;
            parErrNext  = sampleBit !=
              parity_calc(MAX_DATA_BITS'(shiftReg), PARITY_MODE);
            stateNext   = STOP;
          end else begin
            tickCntNext = tickCnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (Tick) begin
          if (midBit) begin
            tickCntNext = '0;
            if (!sampleBit) begin
              frmErrNext = 1'b1;
            end
            if (bitCnt == STOP_LAST) begin
              bitCntNext = '0;
              stateNext  = IDLE;
              armedNext  = sampleBit;
              done       = 1'b1;
            end else begin
              bitCntNext = bitCnt + BW'(1);
            end
          end else begin
            tickCntNext = tickCnt + TW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rxValid     <= 1'b0;
      rxData      <= '0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end else if (done) begin
      rxValid     <= 1'b1;
      rxData      <= shiftReg;
      parityError <= parErr;
      frameError  <= frmErrNext;
      overrun     <= rxValid & ~rxIf.RxAck;
    end else if (rxValid && rxIf.RxAck) begin
      rxValid     <= 1'b0;
      parityError <= 1'b0;
      frameError  <= 1'b0;
      overrun     <= 1'b0;
    end
  end

  assign rxIf.RxValid     = rxValid;
  assign rxIf.RxData      = rxData;
  assign rxIf.ParityError = parityError;
  assign rxIf.FrameError  = frameError;
  assign rxIf.Overrun     = overrun;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: an 8N1 receiver (A) and an 8E2 receiver (B).
module tb_uart_rx_frame;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Tick  = 1'b0;
  logic rxA   = 1'b1;
  logic rxB   = 1'b1;
  logic busyA, busyB;
  logic ackAutoA = 1'b0, ackManA = 1'b0;
  logic ackAutoB = 1'b0;
  logic autoA = 1'b1, autoB = 1'b1;
  logic prevValidA = 1'b0, prevBusyA = 1'b0;
  logic prevValidB = 1'b0, prevBusyB = 1'b0;
  logic seenBusyA = 1'b0;
  int   div = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qA[$];
  exp_t qB[$];

  uart_rx_frame_if #(.DATA_BITS(8)) ifA ();
  uart_rx_frame_if #(.DATA_BITS(8)) ifB ();

  assign ifA.RxAck = ackAutoA | ackManA;
  assign ifB.RxAck = ackAutoB;

  uart_rx_frame #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)
  ) dutA (
    .Clock(Clock), .Reset(Reset), .Rx(rxA), .Tick(Tick),
    .Busy(busyA), .rxIf(ifA)
  );

  uart_rx_frame #(
    .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2)
  ) dutB (
    .Clock(Clock), .Reset(Reset), .Rx(rxB), .Tick(Tick),
    .Busy(busyB), .rxIf(ifB)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    div  = (div + 1) % 4;
    Tick = (div == 0);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    ackAutoA = 1'b0;
    if (busyA) seenBusyA = 1'b1;
    if (!Reset && ifA.RxValid &&
        (!prevValidA || (prevBusyA && !busyA))) begin
      if (qA.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monA unexpected frame got=%h expected=none",
                 ifA.RxData);
      end else begin
        e = qA.pop_front();
        chk("monA", 32'({ifA.RxData, ifA.ParityError,
                         ifA.FrameError, ifA.Overrun}), 32'(e));
      end
      if (autoA) ackAutoA = 1'b1;
    end
    prevValidA = ifA.RxValid;
    prevBusyA  = busyA;
  end

  always @(negedge Clock) begin
    exp_t e;
    ackAutoB = 1'b0;
    if (!Reset && ifB.RxValid &&
        (!prevValidB || (prevBusyB && !busyB))) begin
      if (qB.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monB unexpected frame got=%h expected=none",
                 ifB.RxData);
      end else begin
        e = qB.pop_front();
        chk("monB", 32'({ifB.RxData, ifB.ParityError,
                         ifB.FrameError, ifB.Overrun}), 32'(e));
      end
      if (autoB) ackAutoB = 1'b1;
    end
    prevValidB = ifB.RxValid;
    prevBusyB  = busyB;
  end

  task automatic waitTick();
    @(posedge Clock);
    while (!Tick) @(posedge Clock);
    #1;
  endtask

  task automatic setRx(input int d, input logic v);
    if (d == 0) rxA = v;
    else rxB = v;
  endtask

  task automatic holdBit(input int d, input logic v, input int ticks);
    setRx(d, v);
    repeat (ticks) waitTick();
  endtask

  task automatic sendFrame(input int d, input logic [7:0] data,
                           input logic hasPar, input logic par,
                           input logic s1, input logic s2,
                           input int nStop, input int spikeBit);
    holdBit(d, 1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == spikeBit) begin
        holdBit(d, data[i], 7);
        holdBit(d, ~data[i], 1);
        holdBit(d, data[i], 8);
      end else begin
        holdBit(d, data[i], 16);
      end
    end
    if (hasPar) holdBit(d, par, 16);
    holdBit(d, s1, 16);
    if (nStop == 2) holdBit(d, s2, 16);
    setRx(d, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clock);
    chk("rstValidA", 32'(ifA.RxValid), 32'd0);
    chk("rstDataA", 32'(ifA.RxData), 32'd0);
    chk("rstFlagsA", 32'({ifA.ParityError, ifA.FrameError,
                          ifA.Overrun, busyA}), 32'd0);
    chk("rstB", 32'({ifB.RxValid, ifB.RxData, ifB.ParityError,
                     ifB.FrameError, ifB.Overrun, busyB}), 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (8) waitTick();

    // back-to-back 8N1 frames, acked
    qA.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
    qA.push_back('{8'hA3, 1'b0, 1'b0, 1'b0});
    sendFrame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    sendFrame(0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    repeat (24) waitTick();
    chk("drainA1", 32'(qA.size()), 32'd0);

    // short start glitch
    seenBusyA = 1'b0;
    holdBit(0, 1'b0, 3);
    holdBit(0, 1'b1, 24);
    chk("glitchBusySeen", 32'(seenBusyA), 32'd1);
    chk("glitchIdle", 32'(busyA), 32'd0);
    chk("glitchNoValid", 32'(ifA.RxValid), 32'd0);

    // even parity, two stop bits
    qB.push_back('{8'h07, 1'b1, 1'b0, 1'b0});
    sendFrame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 2, -1);
    qB.push_back('{8'h07, 1'b0, 1'b0, 1'b0});
    sendFrame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 2, -1);
    qB.push_back('{8'h5A, 1'b0, 1'b1, 1'b0});
    sendFrame(1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 2, -1);
    repeat (24) waitTick();
    chk("drainB1", 32'(qB.size()), 32'd0);

    // break: line low for 20 bit times
    qB.push_back('{8'h00, 1'b0, 1'b1, 1'b0});
    holdBit(1, 1'b0, 20 * 16);
    chk("breakNoRetrig", 32'(busyB), 32'd0);
    chk("drainBreak", 32'(qB.size()), 32'd0);
    holdBit(1, 1'b1, 32);
    chk("breakIdle", 32'(busyB), 32'd0);

    // overrun with no ack
    autoA = 1'b0;
    qA.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
    qA.push_back('{8'h22, 1'b0, 1'b0, 1'b1});
    sendFrame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    sendFrame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    repeat (24) waitTick();
    chk("ovrHeld", 32'({ifA.RxValid, ifA.Overrun}), 32'b11);
    @(posedge Clock);
    #1 ackManA = 1'b1;
    @(posedge Clock);
    #1 ackManA = 1'b0;
    chk("ackValid", 32'(ifA.RxValid), 32'd0);
    chk("ackOverrun", 32'(ifA.Overrun), 32'd0);
    chk("ackDataKept", 32'(ifA.RxData), 32'h22);
    autoA = 1'b1;
    repeat (8) waitTick();

    // reset in the middle of 0xF0, bit 4
    holdBit(0, 1'b0, 16);
    holdBit(0, 1'b0, 64);
    holdBit(0, 1'b1, 8);
    chk("busyMidFrame", 32'(busyA), 32'd1);
    Reset = 1'b1;
    #1;
    chk("resetAbort", 32'(busyA), 32'd0);
    rxA = 1'b1;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (32) waitTick();
    chk("abortNoValid", 32'(ifA.RxValid), 32'd0);
    qA.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    sendFrame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
    repeat (24) waitTick();
`ifdef UART_RX_MAJORITY_VOTE_EN
    qA.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
    sendFrame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1, 2);
    repeat (24) waitTick();
`endif

    for (int i = 0; i < 200; i++) begin
      if (qA.size() == 0 && qB.size() == 0) break;
      waitTick();
    end
    chk("finalDrainA", 32'(qA.size()), 32'd0);
    chk("finalDrainB", 32'(qB.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Generalised data width, oversampling ratio, parity mode and stop-bit count.
- Adds start-bit glitch rejection, mid-bit sampling, parity/framing error reporting and a valid/ack output holding register with overrun detection.
- Sits between the RX pad and the system-side consumer (FIFO or CPU register); timed by the shared baud-rate generator's Tick.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9.
OVERSAMPLE, 16, Tick pulses per bit period; even, 8..32.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits checked; 1 or 2.

Ports:
Clock  input  1  system clock; all logic on rising edge.
Reset  input  1  asynchronous, active-high reset.
Rx  input  1  serial line, asynchronous to Clock; idle high.
Tick  input  1  one-Clock enable pulse at OVERSAMPLE x baud rate.
RxAck  input  1  consumer accepts RxData this cycle.
RxValid  output  1  RxData/flags hold an unaccepted frame.
RxData  output  DATA_BITS  received payload, LSB received first.
ParityError  output  1  parity mismatch on the held frame.
FrameError  output  1  a stop bit sampled low on the held frame.
Overrun  output  1  a frame completed while RxValid was still high.
Busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-high) values:
  - All outputs 0; FSM in IDLE; counters and shift register 0.
  - Synchroniser flops reset to 1 (idle line).
- Rx passes through a 2-flop synchroniser; "RxS" below is the synchronised value. Line-to-FSM latency is 2 Clocks.
- Counters advance only on cycles with Tick = 1.
  - TickCnt: ceil(log2 OVERSAMPLE) bits.
  - BitCnt: ceil(log2 DATA_BITS) bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - RxS = 0 -> START, TickCnt = 0.
  - Tick is not required to leave IDLE.
- START:
  - On the tick where TickCnt = OVERSAMPLE/2-1, re-sample RxS.
  - RxS = 0 -> DATA, TickCnt = 0, BitCnt = 0.
  - RxS = 1 -> IDLE (glitch rejected; no outputs change).
- DATA:
  - On the tick where TickCnt = OVERSAMPLE-1 (mid-bit): Shift = {RxS, Shift[DATA_BITS-1:1]}, TickCnt = 0.
  - After bit DATA_BITS-1: -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY:
  - Sample at mid-bit.
  - Even mode: error if XOR of payload and parity bit = 1.
  - Odd mode: error if that XOR = 0.
  - Then -> STOP.
- STOP:
  - Sample at mid-bit, STOP_BITS times.
  - Any low sample latches an internal frame-error bit.
  - On the last stop sample -> IDLE. Return is at mid-stop-bit, so a back-to-back start edge is caught.
- Completion cycle (the cycle the FSM leaves STOP):
  - RxData <= Shift; ParityError and FrameError loaded from the current frame; RxValid <= 1.
  - Overrun <= 1 if RxValid was 1 and RxAck = 0 that cycle; else Overrun <= 0.
  - The newer frame overwrites the held frame.
- Handshake:
  - RxAck while RxValid = 1 clears RxValid, ParityError, FrameError and Overrun next cycle; RxData keeps its value.
  - RxAck while RxValid = 0 is ignored.
  - Completion and RxAck in the same cycle: the new frame loads, RxValid stays 1, Overrun = 0.
- Break condition (all-zero payload, stop bit low): reported as RxData = 0 with FrameError = 1; FSM returns to IDLE and waits for a falling edge.
  - IDLE re-arms only after RxS has been seen high at least once; a sticky line-low never restarts a frame.
- Reset mid-frame: immediate abort to IDLE; no RxValid pulse.
- Busy = (state != IDLE), combinational from state.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each DATA/PARITY/STOP bit value is the 2-of-3 majority of RxS at TickCnt = OVERSAMPLE-2, -1 and 0 (the wrap tick), evaluated on the wrap tick.
  - START confirmation uses the majority at OVERSAMPLE/2-2 .. OVERSAMPLE/2.
  - A single-tick noise spike is ignored.
- Undefined: single sample at the mid-bit tick, as in Behaviour.
- Latency is unchanged either way.

Decomposition:
Shared package uart_pkg holds:
- state enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP};
- parity localparams PAR_NONE/PAR_EVEN/PAR_ODD;
- function parity_calc(data, mode), shared with the future parametrised transmitter.

One sub-module is natural: uart_sync2, the 2-flop synchroniser with a reset value parameter. All other logic stays in uart_rx_frame.

Test Plan:
- 8N1, OVERSAMPLE = 16, send 0x55 then 0xA3 back-to-back, RxAck pulsed after each -> RxData = 0x55 then 0xA3, both with RxValid, no error flags.
- 3-tick low glitch on idle Rx -> FSM returns to IDLE from START; RxValid stays 0; Busy pulses only.
- PARITY_MODE = 1, frame 0x07 with parity bit 0 -> RxData = 0x07, ParityError = 1; the same frame with parity bit 1 -> ParityError = 0.
- STOP_BITS = 2, second stop bit driven low -> FrameError = 1; Rx held low 20 bit-times -> exactly one frame reported (RxData = 0x00, FrameError = 1), no re-trigger until Rx goes high.
- Two frames 0x11, 0x22 with RxAck never asserted -> RxData = 0x22, Overrun = 1; one RxAck -> RxValid = 0, Overrun = 0 next cycle.
- Reset asserted at DATA bit 4 of 0xF0, then released, then send 0x3C -> no output for the aborted frame; 0x3C received cleanly.
  - With UART_RX_MAJORITY_VOTE_EN defined: 1-tick inverted spike at mid-bit 2 of 0x3C -> RxData still 0x3C.
